// File: rtl/aes_round_sequencer_if.sv
// Handshake and control bundle between the AES round sequencer and its neighbours.
// master = block-side driver (rx/tx, key scheduler, downstream); slave = the sequencer.
interface aes_round_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_new_key;
  logic       key_start;
  logic       key_done;
  logic       data_load;
  logic       round_en;
  logic [3:0] cur_round;
  logic       last_round;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       key_err;

  modport master (
    output in_valid, in_new_key, key_done, out_ready,
    input  in_ready, key_start, data_load, round_en, cur_round, last_round, out_valid, busy,
           key_err
  );

  modport slave (
    input  in_valid, in_new_key, key_done, out_ready,
    output in_ready, key_start, data_load, round_en, cur_round, last_round, out_valid, busy,
           key_err
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Sequencer for one AES-128 engine: accepts a block, expands the key when needed, walks the
// round datapath through rounds 0..NUM_ROUNDS and holds the result until taken.
module aes_round_sequencer #(
  parameter int unsigned NUM_ROUNDS  = 10,
  parameter int unsigned KEY_TIMEOUT = 32
) (
  input logic                  clk,
  input logic                  rst,
  aes_round_sequencer_if.slave bus
);
  localparam logic [3:0] LastRound   = 4'(NUM_ROUNDS);
  localparam logic [7:0] TimeoutLast = 8'(KEY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StHold, StKeyStart, StKeyWait, StLoad, StRound
  } state_e;

  state_e     state_q, state_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] tmo_q, tmo_d;
  logic       key_err_q, key_err_d;
  logic [3:0] cur_round_q, cur_round_d;
  logic       key_start_q, key_start_d;
  logic       data_load_q, data_load_d;
  logic       round_en_q, round_en_d;
  logic       last_round_q, last_round_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic       in_ready, accept, need_key;

  // in_ready follows out_ready in HOLD so a new block can enter as the result leaves.
  assign in_ready = (state_q == StIdle) | ((state_q == StHold) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign need_key = bus.in_new_key | ~key_valid_q;

  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    tmo_d       = tmo_q;
    key_err_d   = key_err_q;
    if (accept) begin
      key_err_d = 1'b0;
      if (bus.in_new_key) key_valid_d = 1'b0;
    end
    case (state_q)
      StIdle: begin
        if (accept) state_d = need_key ? StKeyStart : StLoad;
      end
      StHold: begin
        if (accept)             state_d = need_key ? StKeyStart : StLoad;
        else if (bus.out_ready) state_d = StIdle;
      end
      StKeyStart: begin
        tmo_d   = '0;
        state_d = StKeyWait;
      end
      StKeyWait: begin
        tmo_d = (tmo_q == 8'hff) ? tmo_q : tmo_q + 8'd1;
        // key_done has priority over an expiry in the same cycle.
        if (bus.key_done) begin
          key_valid_d = 1'b1;
          state_d     = StLoad;
        end else if (tmo_q == TimeoutLast) begin
          key_valid_d = 1'b0;
          key_err_d   = 1'b1;
          state_d     = StIdle;
        end
      end
      StLoad: state_d = StRound;
      StRound: begin
        if (cur_round_q == LastRound) state_d = StHold;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, decoded from the state being entered.
  always_comb begin
    case (state_d)
      StRound: cur_round_d = (state_q == StLoad) ? 4'd1 : cur_round_q + 4'd1;
      StHold:  cur_round_d = cur_round_q;
      default: cur_round_d = '0;
    endcase
    key_start_d  = (state_d == StKeyStart);
    data_load_d  = (state_d == StLoad);
    round_en_d   = (state_d == StLoad) | (state_d == StRound);
    last_round_d = (state_d == StRound) & (cur_round_d == LastRound);
    out_valid_d  = (state_d == StHold);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      key_valid_q  <= 1'b0;
      tmo_q        <= '0;
      key_err_q    <= 1'b0;
      cur_round_q  <= '0;
      key_start_q  <= 1'b0;
      data_load_q  <= 1'b0;
      round_en_q   <= 1'b0;
      last_round_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_valid_q  <= key_valid_d;
      tmo_q        <= tmo_d;
      key_err_q    <= key_err_d;
      cur_round_q  <= cur_round_d;
      key_start_q  <= key_start_d;
      data_load_q  <= data_load_d;
      round_en_q   <= round_en_d;
      last_round_q <= last_round_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.key_start  = key_start_q;
  assign bus.data_load  = data_load_q;
  assign bus.round_en   = round_en_q;
  assign bus.cur_round  = cur_round_q;
  assign bus.last_round = last_round_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.key_err    = key_err_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: per-block timeline model (key phase, load, rounds, hold)
// driven by directed and randomised transactions.
module tb_aes_round_sequencer;
  localparam int NR = 10;
  localparam int KT = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_sequencer_if bus ();

  aes_round_sequencer #(
    .NUM_ROUNDS (NR),
    .KEY_TIMEOUT(KT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit kv_m = 1'b0;     // model: an expanded key is available
  bit kerr_m = 1'b0;   // model: sticky timeout flag
  bit in_hold = 1'b0;  // previous block left its result waiting

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One block: d = wait cycle (counter value) on which key_done is given, -1 = never.
  task automatic run_block(input bit nk, input int d, input int hold, input bit chain);
    bit need;
    bit done;
    if (in_hold) begin
      chk("hold_before_accept", bus.out_valid, 1);
      bus.out_ready = 1'b1;
    end
    bus.in_valid   = 1'b1;
    bus.in_new_key = nk;
    bus.key_done   = 1'b0;
    #1;
    chk("accept_in_ready", bus.in_ready, 1);
    chk("accept_key_err", bus.key_err, kerr_m);
    need = nk || !kv_m;
    if (nk) kv_m = 1'b0;
    kerr_m = 1'b0;
    step();
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.in_new_key = 1'($urandom % 2);
    in_hold        = 1'b0;
    if (need) begin
      chk("key_start_pulse", bus.key_start, 1);
      chk("key_start_ready", bus.in_ready, 0);
      step();
      done = 1'b0;
      for (int k = 0; k < KT; k++) begin
        chk("key_wait_busy", bus.busy, 1);
        chk("key_wait_no_start", bus.key_start, 0);
        chk("key_wait_out_valid", bus.out_valid, 0);
        bus.key_done = (k == d);
        step();
        if (k == d) begin
          done = 1'b1;
          break;
        end
      end
      bus.key_done = 1'b0;
      if (!done) begin
        chk("timeout_busy", bus.busy, 0);
        chk("timeout_key_err", bus.key_err, 1);
        chk("timeout_out_valid", bus.out_valid, 0);
        chk("timeout_cur_round", bus.cur_round, 0);
        #1 chk("timeout_in_ready", bus.in_ready, 1);
        kerr_m = 1'b1;
        kv_m   = 1'b0;
        return;
      end
      kv_m = 1'b1;
    end else begin
      chk("reuse_no_key_start", bus.key_start, 0);
    end
    chk("load_data_load", bus.data_load, 1);
    chk("load_round_en", bus.round_en, 1);
    chk("load_cur_round", bus.cur_round, 0);
    chk("load_last_round", bus.last_round, 0);
    chk("load_key_err", bus.key_err, 0);
    chk("load_busy", bus.busy, 1);
    bus.key_done = 1'($urandom % 2);
    bus.in_valid = 1'($urandom % 2);
    step();
    for (int r = 1; r <= NR; r++) begin
      chk("round_en", bus.round_en, 1);
      chk("round_data_load", bus.data_load, 0);
      chk("round_cur_round", bus.cur_round, 8'(r));
      chk("round_last_round", bus.last_round, (r == NR) ? 8'd1 : 8'd0);
      chk("round_out_valid", bus.out_valid, 0);
      chk("round_in_ready", bus.in_ready, 0);
      bus.key_done = 1'($urandom % 2);
      bus.in_valid = 1'($urandom % 2);
      step();
    end
    bus.key_done = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_cur_round", bus.cur_round, 8'(NR));
      chk("hold_round_en", bus.round_en, 0);
      chk("hold_last_round", bus.last_round, 0);
      chk("hold_busy", bus.busy, 1);
      #1 chk("hold_in_ready_low", bus.in_ready, 0);
      if (i < hold) step();
    end
    if (chain) begin
      in_hold = 1'b1;
    end else begin
      bus.out_ready = 1'b1;
      #1 chk("release_in_ready", bus.in_ready, 1);
      step();
      bus.out_ready = 1'b0;
      chk("release_busy", bus.busy, 0);
      chk("release_out_valid", bus.out_valid, 0);
      chk("release_cur_round", bus.cur_round, 0);
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_new_key = 1'b0;
    bus.key_done   = 1'b0;
    bus.out_ready  = 1'b0;
    rst            = 1'b1;
    #2;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_key_start", bus.key_start, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_cur_round", bus.cur_round, 0);
    chk("reset_key_err", bus.key_err, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Reset in the middle of ROUND aborts silently.
    bus.in_valid   = 1'b1;
    bus.in_new_key = 1'b1;
    #1 chk("mid_rst_accept", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("mid_rst_key_start", bus.key_start, 1);
    step();
    bus.key_done = 1'b1;
    step();
    bus.key_done = 1'b0;
    repeat (5) step();
    chk("mid_rst_round5", bus.cur_round, 5);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_cur_round", bus.cur_round, 0);
    step();
    rst  = 1'b0;
    kv_m = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("post_rst_out_valid", bus.out_valid, 0);
      chk("post_rst_busy", bus.busy, 0);
      step();
    end

    // First block, key never expanded: done at cycle 17, LOAD at 18, out_valid at 29.
    run_block(1'b0, 15, 0, 1'b0);
    // Same key: no expansion; hold 5 cycles, then accept back-to-back.
    run_block(1'b0, 0, 5, 1'b1);
    run_block(1'b0, 0, 0, 1'b0);
    // Expansion never completes.
    run_block(1'b1, -1, 0, 1'b0);
    // Stray key_done in IDLE must not validate the key.
    bus.key_done = 1'b1;
    step();
    bus.key_done = 1'b0;
    chk("idle_done_busy", bus.busy, 0);
    chk("idle_done_key_start", bus.key_start, 0);
    // key_done on the exact expiry cycle wins.
    run_block(1'b0, KT - 1, 1, 1'b0);

    for (int n = 0; n < 25; n++) begin
      int d;
      d = (($urandom % 8) == 0) ? -1 : int'($urandom % KT);
      run_block(($urandom % 4) == 0, d, int'($urandom % 4), 1'($urandom % 2));
    end
    if (in_hold) run_block(1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
